// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: opcode constants, opcode
// class masks, the control FSM states and the writeback source selector.
package wb_pkg;

  // Opcodes (instr[15:11]) that need a non-ALU writeback source
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_STU  = 5'b10011;
  localparam logic [4:0] OP_LBI  = 5'b11000;
  localparam logic [4:0] OP_SEQ  = 5'b11100;
  localparam logic [4:0] OP_SLT  = 5'b11101;
  localparam logic [4:0] OP_SLE  = 5'b11110;
  localparam logic [4:0] OP_SCO  = 5'b11111;
  localparam logic [4:0] OP_JAL  = 5'b00110;
  localparam logic [4:0] OP_JALR = 5'b00111;

  // Opcode classes: (opcode & CLASS_MASK) == CLASS_xxx
  localparam logic [4:0] CLASS_MASK  = 5'b11100;
  localparam logic [4:0] CLASS_ALU_A = 5'b01000;
  localparam logic [4:0] CLASS_ALU_B = 5'b10100;
  localparam logic [4:0] CLASS_ALU_C = 5'b11000;
  localparam logic [4:0] CLASS_FLAG  = 5'b11100;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

  typedef enum logic [2:0] {
    SRC_ALU  = 3'd0,
    SRC_IMM8 = 3'd1,
    SRC_MEM  = 3'd2,
    SRC_ZERO = 3'd3,
    SRC_LT   = 3'd4,
    SRC_LTE  = 3'd5,
    SRC_CO   = 3'd6,
    SRC_PC2  = 3'd7
  } wb_src_e;

endpackage

// File: rtl/wb_src_sel.sv
// Opcode decoder for the writeback stage: picks which value gets written
// back and flags loads, which must wait for memory before writing.
module wb_src_sel
  import wb_pkg::*;
(
  input  logic [4:0] opcode_i,
  output wb_src_e    src_o,
  output logic       is_load_o
);

  // Everything not explicitly listed (including the ALU classes and
  // LBI's neighbours in 110xx) writes back the ALU result.
  always_comb begin
    src_o     = SRC_ALU;
    is_load_o = 1'b0;
    case (opcode_i)
      OP_LD: begin
        src_o     = SRC_MEM;
        is_load_o = 1'b1;
      end
      OP_LBI:           src_o = SRC_IMM8;
      OP_SEQ:           src_o = SRC_ZERO;
      OP_SLT:           src_o = SRC_LT;
      OP_SLE:           src_o = SRC_LTE;
      OP_SCO:           src_o = SRC_CO;
      OP_JAL, OP_JALR:  src_o = SRC_PC2;
      default:          src_o = SRC_ALU;
    endcase
  end

endmodule

// File: rtl/wb_ctrl_pipe.sv
// Writeback stage of the 16-bit pipelined core. Non-load results are
// written one cycle after acceptance; loads park in WAIT_MEM until the
// memory completes, the timeout expires, or the pipeline flushes.
module wb_ctrl_pipe
  import wb_pkg::*;
#(
  parameter int DW          = 16,
  parameter int RW          = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int FLAG_EXT    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  input  logic [15:0]   instr,
  input  logic [RW-1:0] dest_reg,
  input  logic          reg_wr_en,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] pc_add2,
  input  logic          zero_f,
  input  logic          lt_f,
  input  logic          lte_f,
  input  logic          co_f,
  input  logic [DW-1:0] mem_out,
  input  logic          mem_done,
  output logic          wb_en,
  output logic [RW-1:0] wb_reg,
  output logic [DW-1:0] wb_data,
  output logic          pend_valid,
  output logic [RW-1:0] pend_reg,
  output logic          mem_err
);

  // Counter is wide enough to hold MEM_TIMEOUT itself; it is cleared
  // before it could ever pass that value, so it never wraps.
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW:0] TIMEOUT_VAL = (CW + 1)'(MEM_TIMEOUT);

  wb_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic          wb_en_q, wb_en_d;
  logic [RW-1:0] wb_reg_q, wb_reg_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          pend_valid_q, pend_valid_d;
  logic [RW-1:0] pend_reg_q, pend_reg_d;
  logic          pend_wr_q, pend_wr_d;
  logic          mem_err_q, mem_err_d;

  wb_src_e       src;
  logic          is_load;
  logic          accept;
  logic [DW-1:0] sel_data;
  logic          unused_instr_bits;

  // Only the opcode and the 8-bit immediate matter to this stage
  assign unused_instr_bits = ^instr[10:8];

  wb_src_sel u_src_sel (
    .opcode_i  (instr[15:11]),
    .src_o     (src),
    .is_load_o (is_load)
  );

  assign in_ready = (state_q == IDLE) && !rst;
  assign accept   = in_valid && in_ready && !flush;
  assign cnt_inc  = {1'b0, cnt_q} + {{CW{1'b0}}, 1'b1};

  // Compare results are single bits; widen them either as 0/1 or as an all-ones mask
  function automatic logic [DW-1:0] ext_flag(input logic f);
    if (FLAG_EXT != 0) return {DW{f}};
    else               return {{(DW-1){1'b0}}, f};
  endfunction

  // Mux the writeback value for the instruction being accepted
  always_comb begin
    sel_data = alu_result;
    case (src)
      SRC_ALU:  sel_data = alu_result;
      SRC_IMM8: sel_data = {{(DW-8){instr[7]}}, instr[7:0]};
      SRC_MEM:  sel_data = mem_out;
      SRC_ZERO: sel_data = ext_flag(zero_f);
      SRC_LT:   sel_data = ext_flag(lt_f);
      SRC_LTE:  sel_data = ext_flag(lte_f);
      SRC_CO:   sel_data = ext_flag(co_f);
      SRC_PC2:  sel_data = pc_add2;
      default:  sel_data = alu_result;
    endcase
  end

  // Next-state logic: write strobe and error are one-cycle pulses, flush
  // in WAIT_MEM beats both a same-cycle completion and the timeout, and a
  // completion on the last allowed cycle beats the timeout.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wb_en_d      = 1'b0;
    wb_reg_d     = wb_reg_q;
    wb_data_d    = wb_data_q;
    pend_valid_d = pend_valid_q;
    pend_reg_d   = pend_reg_q;
    pend_wr_d    = pend_wr_q;
    mem_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load) begin
            state_d      = WAIT_MEM;
            cnt_d        = '0;
            pend_valid_d = 1'b1;
            pend_reg_d   = dest_reg;
            pend_wr_d    = reg_wr_en;
          end else if (reg_wr_en) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = dest_reg;
            wb_data_d = sel_data;
          end
        end
      end
      WAIT_MEM: begin
        if (flush) begin
          state_d      = IDLE;
          cnt_d        = '0;
          pend_valid_d = 1'b0;
        end else if (mem_done) begin
          state_d      = IDLE;
          cnt_d        = '0;
          pend_valid_d = 1'b0;
          if (pend_wr_q) begin
            wb_en_d   = 1'b1;
            wb_reg_d  = pend_reg_q;
            wb_data_d = mem_out;
          end
        end else if (cnt_inc == TIMEOUT_VAL) begin
          state_d      = IDLE;
          cnt_d        = '0;
          pend_valid_d = 1'b0;
          mem_err_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc[CW-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any pending load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wb_en_q      <= 1'b0;
      wb_reg_q     <= '0;
      wb_data_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_reg_q   <= '0;
      pend_wr_q    <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wb_en_q      <= wb_en_d;
      wb_reg_q     <= wb_reg_d;
      wb_data_q    <= wb_data_d;
      pend_valid_q <= pend_valid_d;
      pend_reg_q   <= pend_reg_d;
      pend_wr_q    <= pend_wr_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign wb_en      = wb_en_q;
  assign wb_reg     = wb_reg_q;
  assign wb_data    = wb_data_q;
  assign pend_valid = pend_valid_q;
  assign pend_reg   = pend_reg_q;
  assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Self-checking bench for wb_ctrl_pipe. Two instances share all inputs:
// dut uses zero-extended flags, dut1 uses replicated flags.
module tb_wb_ctrl_pipe;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, flush, reg_wr_en, mem_done;
  logic          zero_f, lt_f, lte_f, co_f;
  logic [15:0]   instr;
  logic [RW-1:0] dest_reg;
  logic [DW-1:0] alu_result, pc_add2, mem_out;

  logic          in_ready, wb_en, pend_valid, mem_err;
  logic [RW-1:0] wb_reg, pend_reg;
  logic [DW-1:0] wb_data;

  logic          in_ready1, wb_en1, pend_valid1, mem_err1;
  logic [RW-1:0] wb_reg1, pend_reg1;
  logic [DW-1:0] wb_data1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_ctrl_pipe #(.DW(DW), .RW(RW), .MEM_TIMEOUT(TO), .FLAG_EXT(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .instr(instr), .dest_reg(dest_reg), .reg_wr_en(reg_wr_en), .alu_result(alu_result),
    .pc_add2(pc_add2), .zero_f(zero_f), .lt_f(lt_f), .lte_f(lte_f), .co_f(co_f),
    .mem_out(mem_out), .mem_done(mem_done), .wb_en(wb_en), .wb_reg(wb_reg),
    .wb_data(wb_data), .pend_valid(pend_valid), .pend_reg(pend_reg), .mem_err(mem_err)
  );

  wb_ctrl_pipe #(.DW(DW), .RW(RW), .MEM_TIMEOUT(TO), .FLAG_EXT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .flush(flush),
    .instr(instr), .dest_reg(dest_reg), .reg_wr_en(reg_wr_en), .alu_result(alu_result),
    .pc_add2(pc_add2), .zero_f(zero_f), .lt_f(lt_f), .lte_f(lte_f), .co_f(co_f),
    .mem_out(mem_out), .mem_done(mem_done), .wb_en(wb_en1), .wb_reg(wb_reg1),
    .wb_data(wb_data1), .pend_valid(pend_valid1), .pend_reg(pend_reg1), .mem_err(mem_err1)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    in_valid = 0; flush = 0; reg_wr_en = 0; mem_done = 0;
    zero_f = 0; lt_f = 0; lte_f = 0; co_f = 0;
    instr = '0; dest_reg = '0; alu_result = '0; pc_add2 = '0; mem_out = '0;
  endtask

  // Writeback value from the opcode table, written directly as rules
  function automatic logic [15:0] refData(input logic [15:0] ins, input logic [15:0] alu,
                                          input logic [15:0] pc2, input logic [15:0] mem,
                                          input logic z, input logic l, input logic le,
                                          input logic c, input bit fext);
    int op;
    logic f;
    op = int'(ins[15:11]);
    if (op == 24) return 16'($signed(ins[7:0]));
    if (op == 17) return mem;
    if (op == 6 || op == 7) return pc2;
    if (op >= 28) begin
      case (op)
        28: f = z;
        29: f = l;
        30: f = le;
        default: f = c;
      endcase
      if (fext) return f ? 16'hFFFF : 16'h0000;
      return f ? 16'd1 : 16'd0;
    end
    return alu;
  endfunction

  task automatic test_reset();
    rst = 1;
    clearInputs();
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %0b exp 0", wb_en); end
    checks++; if (wb_reg !== 3'd0) begin errors++; $display("FAIL reset_wb_reg got %0d exp 0", wb_reg); end
    checks++; if (wb_data !== 16'h0) begin errors++; $display("FAIL reset_wb_data got %h exp 0000", wb_data); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL reset_pend_valid got %0b exp 0", pend_valid); end
    checks++; if (pend_reg !== 3'd0) begin errors++; $display("FAIL reset_pend_reg got %0d exp 0", pend_reg); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err got %0b exp 0", mem_err); end
    rst = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %0b exp 1", in_ready); end
  endtask

  task automatic test_alu_write();
    in_valid = 1; instr = 16'h4000; alu_result = 16'h1234; dest_reg = 3'd5; reg_wr_en = 1;
    tick();
    in_valid = 0;
    checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL alu_wb_en got %0b exp 1", wb_en); end
    checks++; if (wb_reg !== 3'd5) begin errors++; $display("FAIL alu_wb_reg got %0d exp 5", wb_reg); end
    checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL alu_wb_data got %h exp 1234", wb_data); end
    tick();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL alu_wb_en_drop got %0b exp 0", wb_en); end
  endtask

  task automatic test_sources();
    reg_wr_en = 1; dest_reg = 3'd2;
    in_valid = 1; instr = 16'hC0F0;
    tick();
    checks++; if (wb_data !== 16'hFFF0) begin errors++; $display("FAIL lbi_data got %h exp fff0", wb_data); end
    instr = 16'hF800; co_f = 1; lte_f = 0;
    tick();
    checks++; if (wb_data !== 16'h0001) begin errors++; $display("FAIL sco_zext got %h exp 0001", wb_data); end
    checks++; if (wb_data1 !== 16'hFFFF) begin errors++; $display("FAIL sco_rep got %h exp ffff", wb_data1); end
    instr = 16'hF000; co_f = 0; lte_f = 1;
    tick();
    checks++; if (wb_data !== 16'h0001) begin errors++; $display("FAIL sle_data got %h exp 0001", wb_data); end
    instr = 16'h3000; pc_add2 = 16'h0102; lte_f = 0;
    tick();
    checks++; if (wb_data !== 16'h0102) begin errors++; $display("FAIL jal_data got %h exp 0102", wb_data); end
    checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL back_to_back_wb_en got %0b exp 1", wb_en); end
    instr = 16'h8000; reg_wr_en = 0; alu_result = 16'h5555;
    tick();
    in_valid = 0;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL store_wb_en got %0b exp 0", wb_en); end
    tick();
  endtask

  // One load whose completion arrives on wait cycle d (never, if d >= TO)
  task automatic run_load(input int d, input logic [RW-1:0] dest, input logic [15:0] val);
    bit expWrite;
    int lastK;
    expWrite = (d < TO);
    lastK = expWrite ? d : TO - 1;
    in_valid = 1; instr = 16'h8800; dest_reg = dest; reg_wr_en = 1; mem_done = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ld_accept_ready got %0b exp 1", in_ready); end
    tick();
    in_valid = 0; dest_reg = ~dest;
    for (int k = 0; k <= lastK; k++) begin
      mem_done = (k == d);
      mem_out = (k == d) ? val : 16'($urandom);
      checks++; if (pend_valid !== 1'b1) begin errors++; $display("FAIL ld_pend_valid k=%0d got %0b exp 1", k, pend_valid); end
      checks++; if (pend_reg !== dest) begin errors++; $display("FAIL ld_pend_reg k=%0d got %0d exp %0d", k, pend_reg, dest); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ld_in_ready k=%0d got %0b exp 0", k, in_ready); end
      tick();
      if (k < lastK) begin
        checks++; if ({wb_en, mem_err} !== 2'b00) begin errors++; $display("FAIL ld_quiet k=%0d got wb_en=%0b mem_err=%0b exp 0 0", k, wb_en, mem_err); end
      end else if (expWrite) begin
        checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL ld_wb_en d=%0d got %0b exp 1", d, wb_en); end
        checks++; if (wb_reg !== dest) begin errors++; $display("FAIL ld_wb_reg d=%0d got %0d exp %0d", d, wb_reg, dest); end
        checks++; if (wb_data !== val) begin errors++; $display("FAIL ld_wb_data d=%0d got %h exp %h", d, wb_data, val); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL ld_no_err d=%0d got %0b exp 0", d, mem_err); end
      end else begin
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL ld_timeout_err got %0b exp 1", mem_err); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL ld_timeout_wb_en got %0b exp 0", wb_en); end
      end
    end
    mem_done = 0;
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL ld_done_pend got %0b exp 0", pend_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ld_done_ready got %0b exp 1", in_ready); end
    tick();
    checks++; if ({wb_en, mem_err} !== 2'b00) begin errors++; $display("FAIL ld_pulse_end got wb_en=%0b mem_err=%0b exp 0 0", wb_en, mem_err); end
  endtask

  task automatic test_load();
    run_load(4, 3'd3, 16'hBEEF);
    run_load(0, 3'd6, 16'h1357);
  endtask

  task automatic test_timeout();
    run_load(100, 3'd1, 16'h0000);
    run_load(TO - 1, 3'd7, 16'hA5A5);
  endtask

  task automatic test_load_random();
    for (int i = 0; i < 10; i++)
      run_load(int'($urandom_range(0, TO + 3)), RW'($urandom), 16'($urandom));
  endtask

  task automatic test_flush();
    in_valid = 1; instr = 16'h8800; dest_reg = 3'd4; reg_wr_en = 1;
    tick();
    in_valid = 0;
    tick();
    flush = 1; mem_done = 1; mem_out = 16'hDEAD;
    tick();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL flush_wait_wb_en got %0b exp 0", wb_en); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_pend got %0b exp 0", pend_valid); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL flush_wait_err got %0b exp 0", mem_err); end
    mem_done = 0;
    in_valid = 1; instr = 16'h4000; alu_result = 16'h7777; dest_reg = 3'd2;
    tick();
    in_valid = 0; flush = 0;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL flush_idle_wb_en got %0b exp 0", wb_en); end
    mem_done = 1; mem_out = 16'h4242;
    tick();
    mem_done = 0;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL idle_mem_done_wb_en got %0b exp 0", wb_en); end
  endtask

  task automatic test_reset_mid_load();
    in_valid = 1; instr = 16'h8800; dest_reg = 3'd5; reg_wr_en = 1;
    tick();
    in_valid = 0;
    tick();
    rst = 1;
    #1;
    checks++; if ({wb_en, pend_valid, mem_err, in_ready} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags got %b exp 0000", {wb_en, pend_valid, mem_err, in_ready}); end
    checks++; if (wb_data !== 16'h0) begin errors++; $display("FAIL rst_mid_wb_data got %h exp 0000", wb_data); end
    tick();
    rst = 0;
    mem_done = 1; mem_out = 16'h9999;
    tick();
    mem_done = 0;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rst_mid_late_done got %0b exp 0", wb_en); end
    checks++; if (pend_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_pend got %0b exp 0", pend_valid); end
  endtask

  // Random stream of non-load instructions with random valid/flush/write-enable
  task automatic test_back_to_back();
    logic expEn;
    logic [RW-1:0] expReg;
    logic [15:0] exp0, exp1;
    int op;
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 31));
      if (op == 17) op = 16;
      instr = {5'(op), 11'($urandom)};
      alu_result = 16'($urandom); pc_add2 = 16'($urandom); mem_out = 16'($urandom);
      {zero_f, lt_f, lte_f, co_f} = 4'($urandom);
      dest_reg = RW'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      reg_wr_en = ($urandom_range(0, 9) < 7);
      expEn = in_valid && !flush && reg_wr_en;
      expReg = dest_reg;
      exp0 = refData(instr, alu_result, pc_add2, mem_out, zero_f, lt_f, lte_f, co_f, 1'b0);
      exp1 = refData(instr, alu_result, pc_add2, mem_out, zero_f, lt_f, lte_f, co_f, 1'b1);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd_in_ready i=%0d got %0b exp 1", i, in_ready); end
      tick();
      checks++; if (wb_en !== expEn) begin errors++; $display("FAIL rnd_wb_en i=%0d got %0b exp %0b", i, wb_en, expEn); end
      if (expEn) begin
        checks++; if (wb_reg !== expReg) begin errors++; $display("FAIL rnd_wb_reg i=%0d got %0d exp %0d", i, wb_reg, expReg); end
        checks++; if (wb_data !== exp0) begin errors++; $display("FAIL rnd_wb_data i=%0d got %h exp %h", i, wb_data, exp0); end
        checks++; if (wb_data1 !== exp1) begin errors++; $display("FAIL rnd_wb_data_rep i=%0d got %h exp %h", i, wb_data1, exp1); end
      end
    end
    in_valid = 0; flush = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_sources();
    test_load();
    test_timeout();
    test_flush();
    test_reset_mid_load();
    test_back_to_back();
    test_load_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_ctrl_pipe.md
Name: wb_ctrl_pipe

Overview:
Registered, parametrised writeback stage for the 16-bit pipelined RISC core. It accepts one retiring instruction per handshake and selects the writeback source by opcode. Load instructions wait a variable number of cycles for memory completion, with a timeout. Register-file write and forwarding outputs come from registers, and a pending-load indication goes to the hazard unit.

Parameters:
DW, 16, data/register width
RW, 3, register-address width
MEM_TIMEOUT, 15, max cycles waiting for mem_done before abort (≥1)
FLAG_EXT, 0, 0 = flag results zero-extended to DW; 1 = flag bit replicated across DW

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  retiring instruction present
in_ready  out  1  stage can accept
flush  in  1  synchronous kill of accepted/pending instruction
instr  in  16  instruction word
dest_reg  in  RW  destination register
reg_wr_en  in  1  instruction writes the register file
alu_result  in  DW  ALU output
pc_add2  in  DW  PC+2
zero_f, lt_f, lte_f, co_f  in  1 each  compare/carry flags
mem_out  in  DW  load data
mem_done  in  1  load data valid this cycle
wb_en  out  1  register-file write strobe (1-cycle pulse)
wb_reg  out  RW  write address
wb_data  out  DW  write data
pend_valid  out  1  load pending in this stage
pend_reg  out  RW  destination of pending load
mem_err  out  1  1-cycle pulse on load timeout

Behaviour:
- Reset: state IDLE, counter 0; wb_en, wb_reg, wb_data, pend_valid, pend_reg, mem_err all 0. in_ready is 0 while rst is high.
- in_ready = (state == IDLE) && !rst. Accept = in_valid && in_ready && !flush.
- Source select on instr[15:11]:
  - 010xx, 101xx, 10011 (STU), 110xx except 11000 → alu_result
  - 11000 (LBI) → sign-extended instr[7:0]
  - 10001 (LD) → mem_out
  - 11100 SEQ → zero_f; 11101 SLT → lt_f; 11110 SLE → lte_f; 11111 SCO → co_f
  - 00110/00111 (JAL/JALR) → pc_add2
  - all others → alu_result
- Flag results are extended per FLAG_EXT. SLE and SCO have distinct opcodes; there is no overlap.
- Non-load accept with reg_wr_en = 1: at the next edge, wb_en = 1, wb_reg = dest_reg, wb_data = selected value. Latency is 1 cycle.
- Accept with reg_wr_en = 0: no write; wb_en stays 0.
- LD accept: go to WAIT_MEM, pend_valid = 1, pend_reg = dest_reg, counter cleared.
- In WAIT_MEM:
  - mem_done = 1 → at the next edge, wb_en = 1 with wb_data = mem_out sampled that cycle. State returns to IDLE and pend_valid drops.
  - mem_done = 0 → counter increments. When counter == MEM_TIMEOUT and mem_done is still 0, pulse mem_err for one cycle, do not write, return to IDLE.
  - mem_done = 1 on the timeout cycle → the write wins; no mem_err.
- wb_en deasserts the cycle after every pulse unless a new write qualifies. Back-to-back non-load accepts give consecutive wb_en cycles.
- flush:
  - In IDLE, flush blocks acceptance; any same-cycle in_valid is dropped.
  - In WAIT_MEM, flush returns to IDLE, clears pend_valid, and suppresses wb_en and mem_err even if mem_done is high the same cycle.
  - flush does not cancel a wb_en already registered.
- mem_done while IDLE is ignored.
- Asynchronous reset mid-load: the pending load is discarded with no write.
- Counter width: clog2(MEM_TIMEOUT+1). It must not wrap.

Decomposition:
- Package wb_pkg holds:
  - opcode constants: OP_LD, OP_LBI, OP_SEQ, OP_SLT, OP_SLE, OP_SCO, OP_JAL, OP_JALR, plus class masks
  - state enum {IDLE, WAIT_MEM}
  - source-select enum {SRC_ALU, SRC_IMM8, SRC_MEM, SRC_ZERO, SRC_LT, SRC_LTE, SRC_CO, SRC_PC2}
- One combinational sub-module, wb_src_sel (instr → source enum, is_load flag), is natural. The FSM, counter and output registers stay in wb_ctrl_pipe.

Test Plan:
1. Reset, then ADDI-class instr 0x4000, alu_result = 0x1234, dest_reg = 5, reg_wr_en = 1 → next cycle wb_en = 1, wb_reg = 5, wb_data = 0x1234; the following cycle wb_en = 0.
2. LBI (instr 0xC0F0) → wb_data = 0xFFF0. SCO with co_f = 1 and FLAG_EXT = 0 → wb_data = 0x0001; with FLAG_EXT = 1 → 0xFFFF. SLE with lte_f = 1 and co_f = 0 → 0x0001.
3. LD (0x8800) with dest_reg = 3; mem_done rises 4 cycles later with mem_out = 0xBEEF → in_ready = 0 and pend_valid = 1 for those cycles, then wb_en = 1 with wb_reg = 3 and wb_data = 0xBEEF, then in_ready = 1.
4. LD with mem_done held low and MEM_TIMEOUT = 15 → mem_err pulses once MEM_TIMEOUT cycles after entering WAIT_MEM, no wb_en, state returns to IDLE. Repeat with mem_done = 1 on the timeout cycle → write occurs and mem_err = 0.
5. LD pending, flush and mem_done high in the same cycle → no wb_en, pend_valid = 0 next cycle. flush with in_valid in IDLE → nothing written.
6. JAL (0x3000), pc_add2 = 0x0102 → wb_data = 0x0102. Store (reg_wr_en = 0) → no wb_en. Assert rst mid-WAIT_MEM → all outputs 0 immediately; a later mem_done causes no write.
